// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction memory port, decode handshake and redirect.
// master = fetch stage, slave = memory/decode/branch side.
interface if_fetch_stage_if;
  logic        imem_en;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_word;
  logic [63:0] inst_pc;
  logic        dec_ready;
  logic        redirect_valid;
  logic [63:0] redirect_target;

  modport master (
    output imem_en, imem_addr,
    output inst_valid, inst_word, inst_pc,
    input  imem_rdata, dec_ready,
    input  redirect_valid, redirect_target
  );

  modport slave (
    input  imem_en, imem_addr,
    input  inst_valid, inst_word, inst_pc,
    output imem_rdata, dec_ready,
    output redirect_valid, redirect_target
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC, 1-cycle imem issue, in-order queue, redirect flush.
// Define IF_FETCH_PREDECODE_EN to fold unconditional B into fetch.
module if_fetch_stage #(
  parameter int          DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input logic clk,
  input logic reset,
  if_fetch_stage_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] word;
    logic [63:0] pc;
  } entry_t;

  entry_t        q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [63:0]   pc;
  logic          inflight;
  logic [63:0]   inflightPc;
  logic          inflightEpoch;
  logic          epoch;

  logic          pop;
  logic          push;
  logic          rspLive;
  logic          selfRedir;
  logic [63:0]   bTarget;
  logic [4:0]    occ;
  logic          issue;
  logic [PW-1:0] headNext;
  logic [PW-1:0] tailNext;
  logic          unusedBits;

  assign unusedBits = ^bus.redirect_target[1:0];

  assign bus.inst_valid = (count != '0) && !bus.redirect_valid;
  assign bus.inst_word  = q[head].word;
  assign bus.inst_pc    = q[head].pc;
  assign pop = bus.inst_valid && bus.dec_ready;

  // Responses from a stale epoch or in a redirect cycle are discarded
  assign rspLive = inflight && (inflightEpoch == epoch)
                && !bus.redirect_valid;

`ifdef IF_FETCH_PREDECODE_EN
  assign selfRedir = rspLive && (bus.imem_rdata[31:26] == 6'b000101);
  assign bTarget   = inflightPc
                   + {{36{bus.imem_rdata[25]}}, bus.imem_rdata[25:0], 2'b00};
`else
  assign selfRedir = 1'b0;
  assign bTarget   = 64'd0;
`endif

  assign push = rspLive && !selfRedir;

  assign occ = 5'(count) + 5'(inflight) - 5'(pop);
  assign issue = reset && (occ < 5'(DEPTH))
              && !bus.redirect_valid && !selfRedir;

  assign bus.imem_en   = issue;
  assign bus.imem_addr = pc;

  assign headNext = (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
  assign tailNext = (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflightPc    <= '0;
      inflightEpoch <= 1'b0;
      epoch         <= 1'b0;
    end else if (bus.redirect_valid) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      epoch    <= ~epoch;
      inflight <= 1'b0;
      pc       <= {bus.redirect_target[63:2], 2'b00};
    end else begin
      unique case (1'b1)
        selfRedir: begin
          epoch <= ~epoch;
          pc    <= bTarget;
        end
        issue:   pc <= pc + 64'd4;
        default: ;
      endcase
      inflight <= issue;
      if (issue) begin
        inflightPc    <= pc;
        inflightEpoch <= epoch;
      end
      if (push) begin
        q[tail] <= '{word: bus.imem_rdata, pc: inflightPc};
        tail    <= tailNext;
      end
      if (pop) head <= headNext;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: stream, stall, redirects, B, reset.
// Memory returns word = address (B word at 0x8 when bMode is set).
module tb_if_fetch_stage;

  logic clk;
  logic reset;
  logic bMode;
  int   checks;
  int   passed;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];

  if_fetch_stage_if bus ();

  if_fetch_stage #(.DEPTH(2), .RESET_PC(64'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (bMode && a == 64'h8) return 32'h1400_0004;
    return a[31:0];
  endfunction

  always @(posedge clk)
    if (bus.imem_en) bus.imem_rdata <= memWord(bus.imem_addr);

  function automatic exp_t mk(input logic [63:0] p);
    exp_t e;
    e.pc   = p;
    e.word = memWord(p);
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.imem_en !== 1'b0)
      $display("FAIL rst_en got %b want 0", bus.imem_en);
    else passed++;
    checks++;
    if (bus.imem_addr !== 64'd0)
      $display("FAIL rst_addr got %h want 0", bus.imem_addr);
    else passed++;
    checks++;
    if (bus.inst_valid !== 1'b0)
      $display("FAIL rst_valid got %b want 0", bus.inst_valid);
    else passed++;
    checks++;
    if (bus.inst_word !== 32'd0)
      $display("FAIL rst_word got %h want 0", bus.inst_word);
    else passed++;
    checks++;
    if (bus.inst_pc !== 64'd0)
      $display("FAIL rst_pc got %h want 0", bus.inst_pc);
    else passed++;
  endtask

  task automatic test_stream();
    exp_t e;
    int pops = 0;
    sb.delete();
    for (int i = 0; i < 40; i++) sb.push_back(mk(64'(4 * i)));
    bus.dec_ready = 1'b1;
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_en !== 1'b1)
        $display("FAIL stream_en c%0d got %b want 1", c, bus.imem_en);
      else passed++;
      if (c == 0) begin
        checks++;
        if (bus.imem_addr !== 64'd0)
          $display("FAIL stream_addr0 got %h want 0", bus.imem_addr);
        else passed++;
      end
      if (c < 3) begin
        checks++;
        if (bus.inst_valid !== (c == 2))
          $display("FAIL stream_valid c%0d got %b want %b",
                   c, bus.inst_valid, c == 2);
        else passed++;
      end
      if (bus.inst_valid && bus.dec_ready) begin
        pops++;
        checks++;
        if (sb.size() == 0)
          $display("FAIL stream_sb got pc %h want none", bus.inst_pc);
        else begin
          e = sb.pop_front();
          if (bus.inst_pc !== e.pc || bus.inst_word !== e.word)
            $display("FAIL stream_pop got %h/%h want %h/%h",
                     bus.inst_pc, bus.inst_word, e.pc, e.word);
          else passed++;
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (pops != 8) $display("FAIL stream_pops got %0d want 8", pops);
    else passed++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    bus.dec_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_en !== 1'b0 || bus.inst_valid !== 1'b1)
        $display("FAIL stall_full c%0d got en=%b v=%b want en=0 v=1",
                 c, bus.imem_en, bus.inst_valid);
      else passed++;
      @(posedge clk);
      #1;
    end
    bus.dec_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (bus.inst_valid !== 1'b1)
        $display("FAIL resume_gap c%0d got %b want 1", c, bus.inst_valid);
      else if (sb.size() == 0)
        $display("FAIL resume_sb got pc %h want none", bus.inst_pc);
      else begin
        e = sb.pop_front();
        if (bus.inst_pc !== e.pc || bus.inst_word !== e.word)
          $display("FAIL resume_pop got %h/%h want %h/%h",
                   bus.inst_pc, bus.inst_word, e.pc, e.word);
        else passed++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    int pops = 0;
    bus.dec_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    sb.delete();
    for (int i = 0; i < 16; i++) sb.push_back(mk(64'h100 + 64'(4 * i)));
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'h100;
    bus.dec_ready       = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (bus.inst_valid !== 1'b0 || bus.imem_en !== 1'b0)
          $display("FAIL redir_n got v=%b en=%b want v=0 en=0",
                   bus.inst_valid, bus.imem_en);
        else passed++;
      end
      if (c == 1) begin
        checks++;
        if (bus.imem_addr !== 64'h100 || bus.imem_en !== 1'b1)
          $display("FAIL redir_issue got %h en=%b want 100 en=1",
                   bus.imem_addr, bus.imem_en);
        else passed++;
      end
      if (c > 0 && c < 4) begin
        checks++;
        if (bus.inst_valid !== (c == 3))
          $display("FAIL redir_valid c%0d got %b want %b",
                   c, bus.inst_valid, c == 3);
        else passed++;
      end
      if (bus.inst_valid && bus.dec_ready) begin
        pops++;
        checks++;
        if (sb.size() == 0)
          $display("FAIL redir_sb got pc %h want none", bus.inst_pc);
        else begin
          e = sb.pop_front();
          if (bus.inst_pc !== e.pc || bus.inst_word !== e.word)
            $display("FAIL redir_pop got %h/%h want %h/%h",
                     bus.inst_pc, bus.inst_word, e.pc, e.word);
          else passed++;
        end
      end
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
    end
    checks++;
    if (pops != 6) $display("FAIL redir_pops got %0d want 6", pops);
    else passed++;
  endtask

  task automatic test_unaligned();
    exp_t e;
    sb.delete();
    for (int i = 0; i < 16; i++) sb.push_back(mk(64'h108 + 64'(4 * i)));
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'h10B;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (bus.imem_addr !== 64'h108)
          $display("FAIL unal_addr got %h want 108", bus.imem_addr);
        else passed++;
      end
      if (bus.inst_valid && bus.dec_ready) begin
        checks++;
        if (sb.size() == 0)
          $display("FAIL unal_sb got pc %h want none", bus.inst_pc);
        else begin
          e = sb.pop_front();
          if (bus.inst_pc !== e.pc || bus.inst_word !== e.word)
            $display("FAIL unal_pop got %h/%h want %h/%h",
                     bus.inst_pc, bus.inst_word, e.pc, e.word);
          else passed++;
        end
      end
      @(posedge clk);
      #1;
      bus.redirect_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    sb.delete();
    for (int i = 0; i < 16; i++) sb.push_back(mk(64'h300 + 64'(4 * i)));
    for (int c = 0; c < 9; c++) begin
      bus.redirect_valid  = (c < 2);
      bus.redirect_target = (c == 0) ? 64'h200 : 64'h300;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (bus.imem_en !== 1'b0)
          $display("FAIL b2b_en got %b want 0", bus.imem_en);
        else passed++;
      end
      if (c == 2) begin
        checks++;
        if (bus.imem_addr !== 64'h300)
          $display("FAIL b2b_addr got %h want 300", bus.imem_addr);
        else passed++;
      end
      if (c < 5) begin
        checks++;
        if (bus.inst_valid !== (c == 4))
          $display("FAIL b2b_valid c%0d got %b want %b",
                   c, bus.inst_valid, c == 4);
        else passed++;
      end
      if (bus.inst_valid && bus.dec_ready) begin
        checks++;
        if (sb.size() == 0)
          $display("FAIL b2b_sb got pc %h want none", bus.inst_pc);
        else begin
          e = sb.pop_front();
          if (bus.inst_pc !== e.pc || bus.inst_word !== e.word)
            $display("FAIL b2b_pop got %h/%h want %h/%h",
                     bus.inst_pc, bus.inst_word, e.pc, e.word);
          else passed++;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.redirect_valid = 1'b0;
  endtask

  task automatic test_branch();
    exp_t e;
    int pops = 0;
    int wantPops;
    reset = 1'b0;
    bMode = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    sb.push_back(mk(64'h0));
    sb.push_back(mk(64'h4));
`ifdef IF_FETCH_PREDECODE_EN
    for (int i = 0; i < 8; i++) sb.push_back(mk(64'h18 + 64'(4 * i)));
    wantPops = 6;
`else
    for (int i = 0; i < 8; i++) sb.push_back(mk(64'h8 + 64'(4 * i)));
    wantPops = 8;
`endif
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.inst_valid && bus.dec_ready) begin
        pops++;
        checks++;
        if (sb.size() == 0)
          $display("FAIL br_sb got pc %h want none", bus.inst_pc);
        else begin
          e = sb.pop_front();
          if (bus.inst_pc !== e.pc || bus.inst_word !== e.word)
            $display("FAIL br_pop got %h/%h want %h/%h",
                     bus.inst_pc, bus.inst_word, e.pc, e.word);
          else passed++;
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (pops != wantPops)
      $display("FAIL br_pops got %0d want %0d", pops, wantPops);
    else passed++;
    bMode = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.imem_en !== 1'b0 || bus.inst_valid !== 1'b0)
      $display("FAIL arst_ctl got en=%b v=%b want 0/0",
               bus.imem_en, bus.inst_valid);
    else passed++;
    checks++;
    if (bus.imem_addr !== 64'd0 || bus.inst_pc !== 64'd0)
      $display("FAIL arst_pc got %h/%h want 0/0",
               bus.imem_addr, bus.inst_pc);
    else passed++;
    checks++;
    if (bus.inst_word !== 32'd0)
      $display("FAIL arst_word got %h want 0", bus.inst_word);
    else passed++;
    @(posedge clk);
    #1;
    sb.delete();
    for (int i = 0; i < 8; i++) sb.push_back(mk(64'(4 * i)));
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 3) begin
        checks++;
        if (bus.inst_valid !== (c == 2) || bus.imem_en !== 1'b1)
          $display("FAIL arst_restart c%0d got v=%b en=%b want v=%b en=1",
                   c, bus.inst_valid, bus.imem_en, c == 2);
        else passed++;
      end
      if (bus.inst_valid && bus.dec_ready) begin
        checks++;
        if (sb.size() == 0)
          $display("FAIL arst_sb got pc %h want none", bus.inst_pc);
        else begin
          e = sb.pop_front();
          if (bus.inst_pc !== e.pc || bus.inst_word !== e.word)
            $display("FAIL arst_pop got %h/%h want %h/%h",
                     bus.inst_pc, bus.inst_word, e.pc, e.word);
          else passed++;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    bMode  = 1'b0;
    reset  = 1'b0;
    bus.dec_ready       = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 64'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_unaligned();
    test_back_to_back();
    test_branch();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
